// File: rtl/ras_ctrl.sv
// ras_ctrl
//
// Return-address-stack controller placed directly in front of a dual-port
// RAS BRAM. Call events (push) become port A writes; return events (pop)
// are answered from a cached top-of-stack register in the same cycle, and
// the entry below is fetched through port B so that the cache can be
// refilled. When the stack is full, further pushes wrap around and
// overwrite the oldest entry.
//
// Optional feature macro: RAS_CTRL_REFILL_BYPASS_EN
//   undefined : pop_ready drops for the single REFILL cycle after a pop,
//               so back-to-back pops run at one every two cycles.
//   defined   : pop_ready is held high; a pop accepted during REFILL is
//               answered straight from bram_dob, giving one pop per cycle.
//
// Parameters
//   DEPTH        stack entries held in BRAM (power of two)
//   WIDTH        return-address width
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   flush        empties the stack, overrides push and pop
//   push_valid   call event, always accepted
//   push_addr    return address to push
//   pop_valid    return event, accepted when pop_ready is high
//   pop_ready    pop acceptance
//   pop_data     predicted return address, valid in the accept cycle
//   pop_empty    stack holds no entries
//   bram_wea     port A write enable
//   bram_waddra  port A write address
//   bram_wia     port A write data
//   bram_reb     port B read enable
//   bram_raddrb  port B read address
//   bram_dob     port B read data, one cycle after bram_reb

module ras_ctrl #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop_valid,
    output logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_empty,
    output logic             bram_wea,
    output logic [ADDR-1:0]  bram_waddra,
    output logic [WIDTH-1:0] bram_wia,
    output logic             bram_reb,
    output logic [ADDR-1:0]  bram_raddrb,
    input  logic [WIDTH-1:0] bram_dob
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    localparam logic [ADDR-1:0] PTR_ONE   = ADDR'(1);
    localparam logic [ADDR-1:0] PTR_TWO   = ADDR'(2);
    localparam logic [ADDR:0]   CNT_ONE   = (ADDR+1)'(1);
    localparam logic [ADDR:0]   CNT_MAX   = (ADDR+1)'(DEPTH);

    logic [ADDR-1:0]  ptr;
    logic [ADDR-1:0]  ptr_next;
    logic [ADDR:0]    count;
    logic [ADDR:0]    count_next;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] top_next;
    logic [0:0]       state;
    logic [0:0]       state_next;

    logic             in_refill;
    logic             count_zero;
    logic             count_one;
    logic             count_full;
    logic             push_fire;
    logic             pop_fire;
    logic [WIDTH-1:0] cur_top;

    assign in_refill  = (state == S_REFILL);
    assign count_zero = (count == '0);
    assign count_one  = (count == CNT_ONE);
    assign count_full = (count == CNT_MAX);

`ifdef RAS_CTRL_REFILL_BYPASS_EN
    // During REFILL the cached top is stale; the correct value is the BRAM
    // read data arriving this cycle, so forward it instead of stalling.
    assign pop_ready = 1'b1;
    assign cur_top   = in_refill ? bram_dob : top;
`else
    assign pop_ready = ~in_refill;
    assign cur_top   = top;
`endif

    // flush masks both events so that neither strobes the BRAM.
    assign push_fire = push_valid & ~flush;
    assign pop_fire  = pop_valid & pop_ready & ~flush;

    // An empty stack predicts nothing, so the data is forced to zero.
    assign pop_empty = count_zero;
    assign pop_data  = count_zero ? '0 : cur_top;

    // Next-state and BRAM strobe decode. Writes only happen with a push and
    // reads only with a pop-only, so the two ports never target one address.
    always_comb begin
        ptr_next    = ptr;
        count_next  = count;
        top_next    = top;
        state_next  = state;
        bram_wea    = 1'b0;
        bram_waddra = '0;
        bram_wia    = '0;
        bram_reb    = 1'b0;
        bram_raddrb = '0;

        if (flush) begin
            ptr_next   = '0;
            count_next = '0;
            state_next = S_IDLE;
        end else if (push_fire && pop_fire && !count_zero) begin
            // Pop and push cancel out: the new address simply replaces the
            // current top entry in place.
            bram_wea    = 1'b1;
            bram_waddra = ptr - PTR_ONE;
            bram_wia    = push_addr;
            top_next    = push_addr;
            state_next  = S_IDLE;
        end else if (push_fire) begin
            // Also covers push+pop on an empty stack. Any pending refill is
            // dropped because the pushed address becomes the new top.
            bram_wea    = 1'b1;
            bram_waddra = ptr;
            bram_wia    = push_addr;
            top_next    = push_addr;
            ptr_next    = ptr + PTR_ONE;
            if (!count_full) begin
                count_next = count + CNT_ONE;
            end
            state_next  = S_IDLE;
        end else if (pop_fire && !count_zero) begin
            ptr_next   = ptr - PTR_ONE;
            count_next = count - CNT_ONE;
            if (!count_one) begin
                // Fetch the entry that becomes the new top after this pop.
                bram_reb    = 1'b1;
                bram_raddrb = ptr - PTR_TWO;
                state_next  = S_REFILL;
            end else begin
                state_next  = S_IDLE;
            end
        end else if (in_refill) begin
            top_next   = bram_dob;
            state_next = S_IDLE;
        end
    end

    // State registers; reset also cancels any refill in flight so the
    // late read data is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            top   <= '0;
            state <= S_IDLE;
        end else begin
            ptr   <= ptr_next;
            count <= count_next;
            top   <= top_next;
            state <= state_next;
        end
    end

endmodule
